// File: rtl/ppu_pixel_fifo.sv
// Pixel FIFO for a tile-based PPU. Whole tile rows arrive as bitplanes and
// leave one pixel per clock. A flush clears the buffer at start of line and
// arms a fine-scroll discard, which silently drops the first few pixels.
// Optional build macro PPU_FIFO_PALETTE_EN: route each pixel through the
// BGP-style palette before output. BPP must be 2 in that build.
module ppu_pixel_fifo #(
    parameter int DEPTH  = 16,
    parameter int BPP    = 2,
    parameter int ROW_PX = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [2:0]              discard,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [BPP*ROW_PX-1:0]   load_planes,
    input  logic                    pop,
    input  logic [7:0]              palette,
    output logic [BPP-1:0]          px_out,
    output logic                    px_valid,
    output logic                    underflow,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][BPP-1:0]  mem;
    logic [ROW_PX-1:0][BPP-1:0] row_px;
    logic [AW-1:0]              rptr, wptr;
    logic [2:0]                 discard_rem;
    logic [BPP-1:0]             head, px_map;
    logic [CW-1:0]              count_nxt;
    logic                       load_acc, dropping, deliver, under, take;

    // Transpose the bitplanes: pixel i takes bit (ROW_PX-1-i) of every plane.
    for (genvar i = 0; i < ROW_PX; i++) begin : g_px
        for (genvar p = 0; p < BPP; p++) begin : g_pl
            assign row_px[i][p] = load_planes[p*ROW_PX + ROW_PX-1-i];
        end
    end

    // A full row must fit; flush blocks loads so a stale row cannot land
    // in the freshly cleared buffer.
    assign load_ready = !flush && (count <= CW'(DEPTH - ROW_PX));
    assign load_acc   = load_valid && load_ready;
    assign dropping   = (discard_rem != 3'd0) && (count != '0);
    assign deliver    = pop && (count != '0) && (discard_rem == 3'd0);
    assign under      = pop && (count == '0) && (discard_rem == 3'd0);
    assign take       = deliver || dropping;
    assign head       = mem[rptr];
    assign count_nxt  = count + (load_acc ? CW'(ROW_PX) : CW'(0)) - (take ? CW'(1) : CW'(0));

`ifdef PPU_FIFO_PALETTE_EN
    assign px_map = palette[{head, 1'b0} +: 2];
`else
    // Palette is ignored in the raw build; the port stays for pin compatibility.
    logic unused_palette;
    assign unused_palette = ^palette;
    assign px_map         = head;
`endif

    // Pixel storage; a row is written as ROW_PX consecutive slots with wrap.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            for (int i = 0; i < ROW_PX; i++) begin
                mem[wptr + AW'(i)] <= row_px[i];
            end
        end
    end

    // Pointers, occupancy, discard counter and registered pixel output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            rptr        <= '0;
            wptr        <= '0;
            discard_rem <= 3'd0;
            px_out      <= '0;
            px_valid    <= 1'b0;
            underflow   <= 1'b0;
        end else if (flush) begin
            count       <= '0;
            rptr        <= '0;
            wptr        <= '0;
            discard_rem <= discard;
            px_valid    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count     <= count_nxt;
            px_valid  <= deliver;
            underflow <= under;
            if (take)     rptr        <= rptr + AW'(1);
            if (load_acc) wptr        <= wptr + AW'(ROW_PX);
            if (dropping) discard_rem <= discard_rem - 3'd1;
            if (deliver)  px_out      <= px_map;
        end
    end
endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Scoreboard bench for ppu_pixel_fifo: a queue-of-pixels reference model
// predicts each clock's outcome, a monitor compares it after the edge.
module tb_ppu_pixel_fifo;
    localparam int DEPTH  = 16;
    localparam int BPP    = 2;
    localparam int ROW_PX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  discard = 3'd0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_planes = '0;
    logic        pop = 1'b0;
    logic [7:0]  palette = 8'h1B;
    logic [1:0]  px_out;
    logic        px_valid;
    logic        underflow;
    logic [4:0]  cnt_o;

    ppu_pixel_fifo #(.DEPTH(DEPTH), .BPP(BPP), .ROW_PX(ROW_PX)) dut (
        .clk(clk), .rst(rst), .flush(flush), .discard(discard),
        .load_valid(load_valid), .load_ready(load_ready), .load_planes(load_planes),
        .pop(pop), .palette(palette), .px_out(px_out), .px_valid(px_valid),
        .underflow(underflow), .count(cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; int px; bit u; int cnt; } rec_t;
    rec_t exp_q[$];
    int   mq[$];
    int   drem = 0;
    int   total = 0;
    int   bad = 0;
    bit   last_acc;

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    function automatic int mapf(input int px);
`ifdef PPU_FIFO_PALETTE_EN
        return (int'(palette) >> (2*px)) & 3;
`else
        return px;
`endif
    endfunction

    // One clock of stimulus; the model predicts what the next edge produces.
    task automatic step(input bit f, input int d, input bit lv, input logic [15:0] pl, input bit pp);
        rec_t r;
        bit   rdy, del, und, drp;
        int   hd, px;
        @(negedge clk);
        flush = f; discard = d[2:0]; load_valid = lv; load_planes = pl; pop = pp;
        rdy = !f && (mq.size() <= DEPTH - ROW_PX);
        #1;
        check("load_ready", int'(load_ready), int'(rdy));
        r = '{v: 1'b0, px: 0, u: 1'b0, cnt: 0};
        last_acc = lv && rdy;
        if (f) begin
            mq.delete();
            drem = d;
        end else begin
            del = pp && mq.size() > 0 && drem == 0;
            und = pp && mq.size() == 0 && drem == 0;
            drp = drem > 0 && mq.size() > 0;
            if (del) begin hd = mq.pop_front(); r.v = 1'b1; r.px = mapf(hd); end
            if (drp) begin void'(mq.pop_front()); drem--; end
            if (last_acc) begin
                for (int i = 0; i < ROW_PX; i++) begin
                    px = 0;
                    for (int p = 0; p < BPP; p++)
                        px |= ((int'(pl) >> (p*ROW_PX + ROW_PX-1-i)) & 1) << p;
                    mq.push_back(px);
                end
            end
            r.u = und;
        end
        r.cnt = mq.size();
        exp_q.push_back(r);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 16'h0, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && (mq.size() > 0 || drem > 0); k++) step(0, 0, 0, 16'h0, 1);
    endtask

    // Monitor: after every edge that has a prediction, compare the outputs.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                check("px_valid", int'(px_valid), int'(r.v));
                check("underflow", int'(underflow), int'(r.u));
                check("count", int'(cnt_o), r.cnt);
                if (r.v) check("px_out", int'(px_out), r.px);
            end
        end
    end

    initial begin
        bit          have;
        logic [15:0] row;
`ifndef PPU_FIFO_PALETTE_EN
        palette = 8'($urandom);
`endif
        // Reset state
        #2;
        check("rst_count", int'(cnt_o), 0);
        check("rst_px_valid", int'(px_valid), 0);
        check("rst_underflow", int'(underflow), 0);
        #20;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ready_after_rst", int'(load_ready), 1);

        // Single row, 8 pops
        step(0, 0, 1, 16'hCCF0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 16'h0, 1);
        idle(1);

        // Fill to 16, then hold a third row while popping
        step(0, 0, 1, 16'h1234, 0);
        step(0, 0, 1, 16'h5678, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 1, 16'h9ABC, 1);
        drain();

        // Flush with fine-scroll discard of 3
        step(1, 3, 0, 16'h0, 0);
        step(0, 0, 1, 16'h00AA, 1);
        idle(3);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 16'h0, 1);
        idle(1);

        // Load and pop together at count 8, then underflow at empty
        step(0, 0, 1, 16'hF00F, 0);
        step(0, 0, 1, 16'h3C3C, 1);
        drain();
        step(0, 0, 0, 16'h0, 1);
        idle(1);

        // All-3 pixels through the palette (or raw)
        step(0, 0, 1, 16'hFFFF, 0);
        step(0, 0, 0, 16'h0, 1);
        drain();

        // Randomised traffic with a producer that holds its row until taken
        have = 1'b0;
        row  = '0;
        for (int k = 0; k < 500; k++) begin
            if (!have && ($urandom % 2) == 0) begin
                row  = 16'($urandom);
                have = 1'b1;
            end
            step(($urandom % 48) == 0, int'($urandom % 8), have, row, ($urandom % 4) != 0);
            if (last_acc) have = 1'b0;
        end
        drain();
        idle(1);

        // Asynchronous reset in mid-stream
        step(0, 0, 1, 16'hA5A5, 0);
        step(0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 16'h0, 1);
        flush = 0; load_valid = 0; pop = 0;
        #1;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("async_rst_count", int'(cnt_o), 0);
        check("async_rst_px_valid", int'(px_valid), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mq.delete();
        drem = 0;
        step(0, 0, 0, 16'h0, 1);
        step(0, 0, 1, 16'h0F0F, 0);
        step(0, 0, 0, 16'h0, 1);
        drain();
        idle(2);
        @(posedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
